// File: rtl/instruction_fetch_queue_pkg.sv
// Core-wide shared definitions for the fetch front end.
//   XLEN / INST_W : address and instruction widths
//   PC_STEP       : byte distance between sequential instruction words
//   BOOT_ADDR     : fetch PC after reset
//   fetch_entry_t : one queued {pc, inst} pair
//   align_pc()    : forces a byte address onto a word boundary
package instruction_fetch_queue_pkg;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid : head entry valid               (fetch -> decode)
//   out_pc    : PC of head entry                (fetch -> decode)
//   out_inst  : instruction of head entry       (fetch -> decode)
//   out_ready : decode accepts head this cycle  (decode -> fetch)
// master = fetch queue side, slave = decode side.
interface instruction_fetch_queue_if;
  import instruction_fetch_queue_pkg::*;

  logic              out_valid;
  logic [XLEN-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;

  modport master (
    output out_valid,
    output out_pc,
    output out_inst,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_inst,
    output out_ready
  );

endinterface

// File: rtl/instruction_fetch_queue_inst_fifo.sv
// inst_fifo: synchronous in-order FIFO with flush.
//   clk, reset : clock, synchronous active-high reset (clears storage too)
//   flush      : empties the FIFO (pointers/count to 0); wins over push
//   push       : write wr_data at the tail (ignored when full or flushing)
//   pop        : drop the head entry (ignored when empty)
//   wr_data    : entry to write
//   rd_data    : head entry, read combinationally from storage
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap for free.
module inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty;

  // Storage is a register array so the head can be read in the same cycle
  // and reset can clear it, keeping the output free of X when empty.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem_reg[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
      count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: holds the fetch PC, reads one instruction word per
// cycle from the asynchronous instruction memory and buffers {pc, inst}
// pairs for decode.
//   clk, reset      : clock, synchronous active-high reset
//   fetch_en        : 1 = fetch may advance this cycle
//   imem_addr       : byte address to instruction memory (fetch PC register)
//   imem_dout       : instruction word for imem_addr, same cycle
//   redirect_valid  : flush queue and restart fetch at redirect_pc
//   redirect_pc     : new fetch PC (low two bits ignored)
//   dec             : decode handshake (out_valid/out_pc/out_inst/out_ready)
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = BOOT_ADDR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_en,
  output logic [XLEN-1:0]           imem_addr,
  input  logic [INST_W-1:0]         imem_dout,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  instruction_fetch_queue_if.master dec
);

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;

  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  // A redirect suppresses the push: the word at fetch_pc belongs to the
  // discarded path. A coincident pop still counts as taken by decode; the
  // flush that follows makes its pointer update irrelevant.
  assign push = fetch_en & ~fifo_full & ~redirect_valid;
  assign pop  = dec.out_valid & dec.out_ready;

  assign wr_entry.pc   = fetch_pc_reg;
  assign wr_entry.inst = imem_dout;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid) begin
      fetch_pc_next = align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  inst_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign imem_addr     = fetch_pc_reg;
  assign dec.out_valid = ~fifo_empty;
  assign dec.out_pc    = head_entry.pc;
  assign dec.out_inst  = head_entry.inst;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue. Stimulus pushes the
// expected {pc, inst} transfers into a scoreboard queue; a negedge monitor
// pops and compares on every out_valid & out_ready transfer.
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;

  instruction_fetch_queue_if dec_if ();

  instruction_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if)
  );

  // Instruction memory model
  assign imem_dout = 32'hA000_0000 | imem_addr;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic expect_xfer(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released just after an edge; the next edge is edge 1.
  task automatic do_reset();
    reset = 1'b1;
    dec_if.out_ready = 1'b0;
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (dec_if.out_valid === 1'b1 && dec_if.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_xfer: got pc=%h inst=%h, expected no transfer",
                 dec_if.out_pc, dec_if.out_inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("xfer pc=%h inst=%h (expected pc=%h inst=%h)",
                 dec_if.out_pc, dec_if.out_inst, e.pc, e.inst);
        check("xfer_pc", dec_if.out_pc, e.pc);
        check("xfer_inst", dec_if.out_inst, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_if.out_ready = 1'b0;

    // Reset state, then stream with out_ready = 1
    do_reset();
    check("reset_out_valid", 32'(dec_if.out_valid), 32'd0);
    check("reset_out_pc", dec_if.out_pc, 32'h0);
    check("reset_out_inst", dec_if.out_inst, 32'h0);
    check("reset_imem_addr", imem_addr, 32'h0);
    dec_if.out_ready = 1'b1;
    expect_xfer(32'h0, 32'hA000_0000);
    expect_xfer(32'h4, 32'hA000_0004);
    expect_xfer(32'h8, 32'hA000_0008);
    step();
    check("first_out_valid", 32'(dec_if.out_valid), 32'd1);
    step();
    step();
    step();
    check_drained("stream_all_seen");

    // Backpressure until full
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("full_imem_addr", imem_addr, 32'h10);
    for (int i = 0; i < 4; i++) step();
    check("full_hold_imem_addr", imem_addr, 32'h10);
    check("full_out_pc", dec_if.out_pc, 32'h0);
    for (int i = 0; i < 5; i++) expect_xfer(32'(i * 4), 32'hA000_0000 | 32'(i * 4));
    dec_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    dec_if.out_ready = 1'b0;
    check_drained("full_all_seen");

    // Redirect with 3 queued entries and a coincident pop
    do_reset();
    step();
    step();
    step();
    expect_xfer(32'h0, 32'hA000_0000);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    dec_if.out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("redirect_bubble", 32'(dec_if.out_valid), 32'd0);
    check("redirect_imem_addr", imem_addr, 32'h100);
    expect_xfer(32'h100, 32'hA000_0100);
    step();
    step();
    dec_if.out_ready = 1'b0;
    check_drained("redirect_all_seen");

    // PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    dec_if.out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    expect_xfer(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    expect_xfer(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    expect_xfer(32'h0000_0000, 32'hA000_0000);
    step();
    step();
    step();
    check("wrap_imem_addr", imem_addr, 32'h4);
    step();
    dec_if.out_ready = 1'b0;
    check_drained("wrap_all_seen");

    // fetch_en low for 3 cycles: drain and hold PC
    do_reset();
    step();
    step();
    fetch_en = 1'b0;
    dec_if.out_ready = 1'b1;
    expect_xfer(32'h0, 32'hA000_0000);
    expect_xfer(32'h4, 32'hA000_0004);
    step();
    step();
    step();
    check("hold_drained", 32'(dec_if.out_valid), 32'd0);
    check("hold_imem_addr", imem_addr, 32'h8);
    fetch_en = 1'b1;
    expect_xfer(32'h8, 32'hA000_0008);
    expect_xfer(32'hC, 32'hA000_000C);
    step();
    step();
    step();
    dec_if.out_ready = 1'b0;
    check_drained("hold_all_seen");

    // Reset overrides a concurrent redirect mid-stream
    do_reset();
    step();
    step();
    step();
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    reset = 1'b0;
    check("midreset_out_valid", 32'(dec_if.out_valid), 32'd0);
    check("midreset_imem_addr", imem_addr, 32'h0);
    check("midreset_out_inst", dec_if.out_inst, 32'h0);
    step();
    check("midreset_restart_pc", dec_if.out_pc, 32'h0);
    check_drained("final_all_seen");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
